// File: rtl/sys_drain_pkg.sv
// sys_drain_pkg: shared constants and types for the systolic-array output drain.
package sys_drain_pkg;
  localparam int SYSTOLIC_ARRAY_WIDTH = 2;
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;
  typedef enum logic {IDLE, DRAIN} state_t;
  typedef logic [SYSTOLIC_ARRAY_WIDTH-1:0] mask_t;
endpackage

// File: rtl/sys_drain_postproc.sv
// drain_postproc: one column's saturating signed bias add followed by optional ReLU.
module drain_postproc
  import sys_drain_pkg::*;
(
  input  logic [15:0] data_i,
  input  logic [15:0] bias_i,
  input  logic        relu_en_i,
  input  logic        en_i,
  output logic [15:0] res_o
);
  logic [16:0] sum;
  logic [15:0] sat;
  always_comb begin
    sum = {data_i[15], data_i} + {bias_i[15], bias_i};
    sat = (sum[16] != sum[15]) ? (sum[16] ? SAT_MIN : SAT_MAX) : sum[15:0];
    res_o = (!en_i || (relu_en_i && sat[15])) ? 16'h0000 : sat;
  end
endmodule

// File: rtl/sys_drain.sv
// sys_drain: deskews the two psum columns into rows, post-processes them and
// writes one row per cycle to the unified buffer at consecutive addresses.
module sys_drain #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid_in,
  input  logic [ADDR_WIDTH-1:0]           cfg_base_addr_in,
  input  logic [15:0]                     cfg_row_count_in,
  input  logic [15:0]                     cfg_col_size_in,
  input  logic                            cfg_relu_en_in,
  input  logic [15:0]                     bias_x1_in,
  input  logic [15:0]                     bias_x2_in,
  input  logic [15:0]                     sys_data_out_x1,
  input  logic [15:0]                     sys_data_out_x2,
  input  logic                            sys_valid_out_x1,
  input  logic                            sys_valid_out_x2,
  output logic                            ub_wr_valid_out,
  output logic [ADDR_WIDTH-1:0]           ub_wr_addr_out,
  output logic [15:0]                     ub_wr_data_x1_out,
  output logic [15:0]                     ub_wr_data_x2_out,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] ub_wr_mask_out,
  output logic                            drain_busy_out,
  output logic                            drain_done_out,
  output logic                            drain_err_out
);
  import sys_drain_pkg::*;
  state_t state_q, state_d;
  logic d1_valid_q;
  logic [15:0] d1_data_q;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [15:0] rows_q, rows_d, row_q, row_d, bias1_q, bias1_d, bias2_q, bias2_d;
  logic [15:0] data1_q, data1_d, data2_q, data2_d, res1, res2;
  logic col2_q, col2_d, relu_q, relu_d, wr_q, wr_d, done_q, done_d;
  logic busy_q, busy_d, err_q, err_d, fire, cfg_ok;
  mask_t mask_q, mask_d, mask;
  // Column 1 runs one cycle ahead of column 2; d1 lines the two up.
  assign fire = d1_valid_q | (col2_q & sys_valid_out_x2);
  assign mask = col2_q ? {sys_valid_out_x2, d1_valid_q} : 2'b01;
  assign cfg_ok = (cfg_row_count_in != 16'd0) && (cfg_col_size_in != 16'd0);
  drain_postproc u_pp1 (.data_i(d1_data_q), .bias_i(bias1_q), .relu_en_i(relu_q), .en_i(mask[0]), .res_o(res1));
  drain_postproc u_pp2 (.data_i(sys_data_out_x2), .bias_i(bias2_q), .relu_en_i(relu_q), .en_i(mask[1]), .res_o(res2));
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    rows_d = rows_q;
    row_d = row_q;
    bias1_d = bias1_q;
    bias2_d = bias2_q;
    col2_d = col2_q;
    relu_d = relu_q;
    err_d = err_q;
    wr_d = 1'b0;
    done_d = 1'b0;
    addr_d = '0;
    data1_d = 16'h0000;
    data2_d = 16'h0000;
    mask_d = '0;
    busy_d = (state_q == DRAIN) || (cfg_valid_in && cfg_ok);
    if (state_q == IDLE) begin
      if (cfg_valid_in && cfg_ok) begin
        state_d = DRAIN;
        base_d = cfg_base_addr_in;
        rows_d = cfg_row_count_in;
        row_d = 16'd0;
        bias1_d = bias_x1_in;
        bias2_d = bias_x2_in;
        col2_d = cfg_col_size_in > 16'd1;
        relu_d = cfg_relu_en_in;
        err_d = 1'b0;
      end else begin
        done_d = cfg_valid_in;
        err_d = err_q | sys_valid_out_x1 | sys_valid_out_x2;
      end
    end else begin
      err_d = err_q | cfg_valid_in | (fire && col2_q && (mask[0] != mask[1]));
      if (fire) begin
        wr_d = 1'b1;
        addr_d = base_q + ADDR_WIDTH'(row_q);
        data1_d = res1;
        data2_d = res2;
        mask_d = mask;
        row_d = row_q + 16'd1;
        done_d = row_q == rows_q - 16'd1;
        state_d = done_d ? IDLE : DRAIN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      d1_valid_q <= 1'b0;
      d1_data_q <= 16'h0000;
      base_q <= '0;
      rows_q <= 16'd0;
      row_q <= 16'd0;
      bias1_q <= 16'h0000;
      bias2_q <= 16'h0000;
      col2_q <= 1'b0;
      relu_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data1_q <= 16'h0000;
      data2_q <= 16'h0000;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      d1_valid_q <= sys_valid_out_x1;
      d1_data_q <= sys_data_out_x1;
      base_q <= base_d;
      rows_q <= rows_d;
      row_q <= row_d;
      bias1_q <= bias1_d;
      bias2_q <= bias2_d;
      col2_q <= col2_d;
      relu_q <= relu_d;
      err_q <= err_d;
      wr_q <= wr_d;
      done_q <= done_d;
      busy_q <= busy_d;
      addr_q <= addr_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      mask_q <= mask_d;
    end
  end
  assign ub_wr_valid_out = wr_q;
  assign ub_wr_addr_out = addr_q;
  assign ub_wr_data_x1_out = data1_q;
  assign ub_wr_data_x2_out = data2_q;
  assign ub_wr_mask_out = mask_q;
  assign drain_busy_out = busy_q;
  assign drain_done_out = done_q;
  assign drain_err_out = err_q;
endmodule
